maxnet_result_collector: RTL and testbench
==========================================

// Module: maxnet_result_collector
// PURPOSE
// - Downstream sequencing/result stage of the MaxNet winner-take-all engine.
// - On a host start request, holds MaxNet in reset for a fixed window, then releases it.
// - Waits for a rising edge on MaxNet done, or a timeout, and captures the 5-bit max.
// - Presents the captured result to the host over a valid/ready handshake, with a latency count and a run counter.
// PARAMETERS
// - DATA_W      5    width of MaxNet max output and of res_max
// - RST_CYCLES  2    cycles mn_rst is held high per run (>=1)
// - TIMEOUT     255  RUN-state cycle limit before a timeout result is forced (>=2)
// - CNT_W       8    width of res_cycles and run_count; must hold TIMEOUT
// PORTS
// - clk         in   1       single clock, rising edge
// - rst         in   1       asynchronous, active-low reset
// - start       in   1       host run request; sampled only in IDLE
// - busy        out  1       high in every state except IDLE
// - mn_rst      out  1       active-high reset driven to MaxNet
// - mn_done     in   1       MaxNet done level
// - mn_max      in   DATA_W  MaxNet max value; valid when mn_done rises
// - res_valid   out  1       result held for host
// - res_ready   in   1       host accepts result
// - res_max     out  DATA_W  captured max; 0 on timeout
// - res_timeout out  1       result was forced by timeout
// - res_cycles  out  CNT_W   RUN cycles from MaxNet release to capture
// - run_count   out  CNT_W   completed handshakes; saturates at all-ones
// BEHAVIOUR
// - Reset (rst=0, async):
//   - state=IDLE; mn_rst=1, so MaxNet is held while this block is in reset.
//   - busy, res_valid, res_timeout=0; res_max, res_cycles, run_count=0; done_q=0.
// - First clock after rst deasserts: mn_rst drops to 0 in IDLE.
// - done_q is a register loaded with mn_done every cycle, in every state.
// - The edge term is done_rise = mn_done & ~done_q.
// - IDLE:
//   - On start=1, go to RESET_MN and clear cyc_cnt.
//   - No other outputs change.
// - RESET_MN:
//   - mn_rst=1 for exactly RST_CYCLES cycles, then go to RUN with cyc_cnt=0.
//   - done_rise in this state is ignored.
// - RUN:
//   - mn_rst=0; cyc_cnt increments each cycle.
//   - If done_rise: res_max<=mn_max, res_timeout<=0, res_cycles<=cyc_cnt+1, res_valid<=1, go to HOLD.
//   - Else if cyc_cnt==TIMEOUT-1: res_max<=0, res_timeout<=1, res_cycles<=TIMEOUT, res_valid<=1, go to HOLD.
//   - If done_rise and timeout occur in the same cycle, done wins.
//   - A mn_done level that is high on entry with done_q=1 is not an edge, so the run times out.
// - HOLD:
//   - res_* are stable while res_valid=1 & res_ready=0.
//   - On res_ready=1: res_valid<=0, run_count<=run_count+1 (saturating), go to IDLE.
//   - start is ignored in HOLD, including when it coincides with res_ready; the host must reissue start in IDLE.
// - start in RESET_MN or RUN is ignored; a run cannot be restarted mid-flight.
// - Latency: a start pulse in IDLE produces mn_rst=1 on the next edge.
// - res_ready while res_valid=0 has no effect.
// - Reset asserted mid-run returns to IDLE immediately and discards any partial result; run_count also clears.
// - res_cycles and run_count are unsigned; cyc_cnt never exceeds TIMEOUT.
// STRUCTURE
// - Package maxnet_pkg:
//   - typedef enum logic [1:0] {IDLE, RESET_MN, RUN, HOLD} mn_coll_state_t
//   - default constants MN_DATA_W=5, MN_TIMEOUT=255
// - One sub-module: sat_counter.
//   - CNT_W bits; clear/inc inputs; async active-low reset; saturates at max.
//   - Instantiated twice: cyc_cnt (RESET_MN window and RUN timing) and run_count.
// - Everything else (FSM, done_q, result registers) is inline.
// TESTING
// - Reset: rst=0 for 3 cycles -> mn_rst=1, res_valid=0, run_count=0, busy=0; after release, mn_rst=0 in IDLE.
// - Normal run: start pulse; mn_done rises 20 cycles after release with mn_max=5'd19.
//   - Expect mn_rst high for 2 cycles, then res_valid=1, res_max=19, res_timeout=0, res_cycles=20.
//   - After res_ready: run_count=1, busy=0.
// - Timeout: mn_done held at 0 -> after 255 RUN cycles, res_valid=1, res_timeout=1, res_max=0, res_cycles=255.
// - Stale done: mn_done stuck high across the whole run -> no edge, so a timeout result.
//   - Same-cycle done_rise on the final cycle -> done result.
// - Backpressure: res_ready=0 for 10 cycles in HOLD with start toggling -> res_* stable, no new run.
//   - res_ready=1 together with start=1 -> IDLE, no run started.
// - Mid-run reset: rst=0 at RUN cycle 7 -> immediate IDLE, mn_rst=1, res_valid=0, run_count=0.
//   - Next start runs cleanly.

Source files
------------

// File: rtl/maxnet_pkg.sv
// rtl/maxnet_pkg.sv - shared types and default constants for the MaxNet result collector
package maxnet_pkg;

    typedef enum logic [1:0] {IDLE, RESET_MN, RUN, HOLD} mn_coll_state_t;

    localparam int MN_DATA_W     = 5;
    localparam int MN_TIMEOUT    = 255;
    localparam int MN_CNT_W      = 8;
    localparam int MN_RST_CYCLES = 2;

endpackage

// File: rtl/maxnet_result_collector_if.sv
// rtl/maxnet_result_collector_if.sv - host run control, MaxNet link and result handshake bundle
interface maxnet_result_collector_if
    import maxnet_pkg::*;
#(
    parameter int DATA_W = MN_DATA_W,
    parameter int CNT_W  = MN_CNT_W
);
    logic              start;
    logic              busy;
    logic              mn_rst;
    logic              mn_done;
    logic [DATA_W-1:0] mn_max;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_max;
    logic              res_timeout;
    logic [CNT_W-1:0]  res_cycles;
    logic [CNT_W-1:0]  run_count;

    modport master (
        output start, mn_done, mn_max, res_ready,
        input  busy, mn_rst, res_valid, res_max, res_timeout, res_cycles, run_count
    );

    modport slave (
        input  start, mn_done, mn_max, res_ready,
        output busy, mn_rst, res_valid, res_max, res_timeout, res_cycles, run_count
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable up-counter that sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/maxnet_result_collector.sv
// rtl/maxnet_result_collector.sv - sequences a MaxNet run and hands the captured winner to the host
module maxnet_result_collector
    import maxnet_pkg::*;
#(
    parameter int DATA_W     = MN_DATA_W,
    parameter int RST_CYCLES = MN_RST_CYCLES,
    parameter int TIMEOUT    = MN_TIMEOUT,
    parameter int CNT_W      = MN_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    maxnet_result_collector_if.slave bus
);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT);

    mn_coll_state_t    state, next_state;
    logic              done_q, done_rise;
    logic              mn_rst_q;
    logic [CNT_W-1:0]  cyc_cnt, run_cnt;
    logic              cyc_clear, cyc_inc, run_inc, cap_done, cap_tmo;
    logic              res_valid_q, res_timeout_q;
    logic [DATA_W-1:0] res_max_q;
    logic [CNT_W-1:0]  res_cycles_q;

    assign done_rise = bus.mn_done & ~done_q;

    // One counter times both the MaxNet reset window and the RUN phase
    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk(clk), .rst_n(rst), .clear(cyc_clear), .inc(cyc_inc), .count(cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_run_count (
        .clk(clk), .rst_n(rst), .clear(1'b0), .inc(run_inc), .count(run_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (bus.start)                          next_state = RESET_MN;
            RESET_MN: if (cyc_cnt == RST_LAST)                next_state = RUN;
            RUN:      if (done_rise || (cyc_cnt == TMO_LAST)) next_state = HOLD;
            HOLD:     if (bus.res_ready)                      next_state = IDLE;
            default:                                          next_state = IDLE;
        endcase
    end

    always_comb begin
        cyc_clear = ((state == IDLE) && bus.start) ||
                    ((state == RESET_MN) && (cyc_cnt == RST_LAST));
        cyc_inc   = ((state == RESET_MN) && (cyc_cnt != RST_LAST)) || (state == RUN);
        cap_done  = (state == RUN) && done_rise;
        cap_tmo   = (state == RUN) && !done_rise && (cyc_cnt == TMO_LAST);
        run_inc   = (state == HOLD) && bus.res_ready;
    end

    // mn_rst resets high so MaxNet stays held while this block is itself in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q        <= 1'b0;
            mn_rst_q      <= 1'b1;
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            res_max_q     <= '0;
            res_cycles_q  <= '0;
        end else begin
            done_q   <= bus.mn_done;
            mn_rst_q <= (next_state == RESET_MN);
            if (cap_done) begin
                res_max_q     <= bus.mn_max;
                res_timeout_q <= 1'b0;
                res_cycles_q  <= cyc_cnt + CNT_W'(1);
                res_valid_q   <= 1'b1;
            end else if (cap_tmo) begin
                res_max_q     <= '0;
                res_timeout_q <= 1'b1;
                res_cycles_q  <= TMO_VAL;
                res_valid_q   <= 1'b1;
            end else if (run_inc) begin
                res_valid_q   <= 1'b0;
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.mn_rst      = mn_rst_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_max     = res_max_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.res_cycles  = res_cycles_q;
    assign bus.run_count   = run_cnt;
endmodule

// File: tb/tb_maxnet_result_collector.sv
// tb/tb_maxnet_result_collector.sv - scoreboard bench for the MaxNet result collector
module tb_maxnet_result_collector;
    import maxnet_pkg::*;

    typedef struct {
        logic [4:0] max;
        logic       tmo;
        logic [7:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    int   exp_rc  = 0;
    int   nrst;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    maxnet_result_collector_if #(.DATA_W(5), .CNT_W(8)) bus ();

    maxnet_result_collector #(
        .DATA_W(5), .RST_CYCLES(2), .TIMEOUT(255), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic monitor_loop();
        logic prev_v = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.res_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: got res_max=%0d expected no result", bus.res_max);
                end else begin
                    e = exp_q.pop_front();
                    check("res_max", 32'(bus.res_max), 32'(e.max));
                    check("res_timeout", 32'(bus.res_timeout), 32'(e.tmo));
                    check("res_cycles", 32'(bus.res_cycles), 32'(e.cyc));
                end
            end
            prev_v = bus.res_valid;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Returns on the first negedge of RUN cycle 0
    task automatic count_rst(output int n);
        n = 0;
        while (bus.mn_rst && n < 10) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.res_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bus.res_valid) begin
            n_total++;
            $display("FAIL res_valid_wait: got res_valid=0 expected 1 within %0d cycles", budget);
        end
    endtask

    task automatic accept();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        exp_rc++;
        check("run_count", 32'(bus.run_count), 32'(exp_rc));
        check("busy_after_accept", 32'(bus.busy), 32'd0);
        check("valid_after_accept", 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0;
        bus.mn_done = 1'b0;
        bus.mn_max = '0;
        bus.res_ready = 1'b0;
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        check("reset_mn_rst", 32'(bus.mn_rst), 32'd1);
        check("reset_res_valid", 32'(bus.res_valid), 32'd0);
        check("reset_run_count", 32'(bus.run_count), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_res_timeout", 32'(bus.res_timeout), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_mn_rst", 32'(bus.mn_rst), 32'd0);

        // Normal run: done rises in RUN cycle 19
        exp_q.push_back('{max: 5'd19, tmo: 1'b0, cyc: 8'd20});
        do_start();
        count_rst(nrst);
        check("mn_rst_len", 32'(nrst), 32'd2);
        repeat (19) @(negedge clk);
        bus.mn_done = 1'b1;
        bus.mn_max = 5'd19;
        wait_valid(20);
        accept();
        bus.mn_done = 1'b0;

        // Timeout
        exp_q.push_back('{max: 5'd0, tmo: 1'b1, cyc: 8'd255});
        do_start();
        count_rst(nrst);
        wait_valid(300);
        accept();

        // Stale done level
        bus.mn_done = 1'b1;
        bus.mn_max = 5'd9;
        exp_q.push_back('{max: 5'd0, tmo: 1'b1, cyc: 8'd255});
        do_start();
        count_rst(nrst);
        wait_valid(300);
        accept();
        bus.mn_done = 1'b0;

        // Done edge on the final RUN cycle beats the timeout
        exp_q.push_back('{max: 5'd21, tmo: 1'b0, cyc: 8'd255});
        do_start();
        count_rst(nrst);
        repeat (254) @(negedge clk);
        bus.mn_done = 1'b1;
        bus.mn_max = 5'd21;
        wait_valid(5);

        // Backpressure with start toggling
        for (int i = 0; i < 10; i++) begin
            bus.start = (i % 2 == 0);
            @(negedge clk);
            check("bp_valid", 32'(bus.res_valid), 32'd1);
            check("bp_max", 32'(bus.res_max), 32'd21);
            check("bp_cycles", 32'(bus.res_cycles), 32'd255);
            check("bp_busy", 32'(bus.busy), 32'd1);
        end
        bus.start = 1'b1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.res_ready = 1'b0;
        exp_rc++;
        check("bp_run_count", 32'(bus.run_count), 32'(exp_rc));
        check("bp_busy_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("bp_no_restart_busy", 32'(bus.busy), 32'd0);
        check("bp_no_restart_mn_rst", 32'(bus.mn_rst), 32'd0);
        bus.mn_done = 1'b0;

        // Mid-run reset at RUN cycle 7
        do_start();
        count_rst(nrst);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_mn_rst", 32'(bus.mn_rst), 32'd1);
        check("midrst_valid", 32'(bus.res_valid), 32'd0);
        check("midrst_run_count", 32'(bus.run_count), 32'd0);
        exp_rc = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_idle_mn_rst", 32'(bus.mn_rst), 32'd0);

        exp_q.push_back('{max: 5'd3, tmo: 1'b0, cyc: 8'd5});
        do_start();
        count_rst(nrst);
        check("mn_rst_len2", 32'(nrst), 32'd2);
        repeat (4) @(negedge clk);
        bus.mn_done = 1'b1;
        bus.mn_max = 5'd3;
        wait_valid(10);
        accept();
        bus.mn_done = 1'b0;

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
